// File: rtl/imm_extend_stage_if.sv
// ---------------------------------------------------------------------------
// imm_extend_stage_if
// Bundles the upstream (instruction in) and downstream (immediate out)
// valid/ready handshakes of the immediate generator, plus the pipeline flush.
//
//   flush        : synchronous pipeline flush (driven by the environment)
//   in_valid     : upstream has an instruction
//   in_ready     : stage can accept this cycle
//   in_instr     : raw 32-bit instruction word
//   in_imm_src   : 3-bit immediate format select
//   in_tag       : sideband tag, carried through unmodified
//   out_valid    : out_* hold a result
//   out_ready    : downstream accepts
//   out_imm      : XLEN-bit extended immediate
//   out_tag      : tag belonging to out_imm
//   out_illegal  : result came from an illegal format select
//
// Modports: master = environment side, slave = the stage itself.
// ---------------------------------------------------------------------------
interface imm_extend_stage_if #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic [2:0]           in_imm_src;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_imm;
    logic [TAG_WIDTH-1:0] out_tag;
    logic                 out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_imm_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_imm_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_extend_stage.sv
// ---------------------------------------------------------------------------
// imm_extend_stage
// Decode-stage immediate generator for RV32I/RV64I. Extracts the I, S, B, U,
// J, shift-amount and CSR-uimm immediates from a raw instruction, extends them
// to XLEN bits and registers the result together with a sideband tag and an
// illegal-select flag. A two-entry main/skid buffer provides full throughput
// under backpressure with in_ready driven purely from registered state.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : imm_extend_stage_if.slave (flush, in_* / out_* handshakes)
// Parameters:
//   XLEN      : 32 or 64, width of out_imm
//   TAG_WIDTH : width of the sideband tag
// ---------------------------------------------------------------------------
module imm_extend_stage #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imm_extend_stage_if.slave     bus
);

    typedef struct packed {
        logic [XLEN-1:0]      imm;
        logic [TAG_WIDTH-1:0] tag;
        logic                 illegal;
    } entry_t;

    localparam logic [2:0] SRC_I     = 3'b000;
    localparam logic [2:0] SRC_S     = 3'b001;
    localparam logic [2:0] SRC_B     = 3'b010;
    localparam logic [2:0] SRC_U     = 3'b011;
    localparam logic [2:0] SRC_J     = 3'b100;
    localparam logic [2:0] SRC_SHAMT = 3'b101;
    localparam logic [2:0] SRC_CSR   = 3'b110;

    // RV64 shift amounts are 6 bits wide; RV32 ones only 5.
    localparam bit SHAMT_WIDE = (XLEN == 64);

    entry_t main_reg, main_next;
    entry_t skid_reg, skid_next;
    logic   main_valid_reg, main_valid_next;
    logic   skid_valid_reg, skid_valid_next;

    logic [31:0] instr;
    logic [63:0] imm_full;
    logic        imm_illegal;
    entry_t      new_entry;
    logic        accept;
    logic        transfer;

    assign instr = bus.in_instr;

    // -----------------------------------------------------------------------
    // Extraction: always built at 64 bits, then truncated to XLEN. This keeps
    // the replication counts positive for both legal XLEN values.
    // -----------------------------------------------------------------------
    always_comb begin
        imm_full    = 64'd0;
        imm_illegal = 1'b0;
        case (bus.in_imm_src)
            SRC_I:     imm_full = {{52{instr[31]}}, instr[31:20]};
            SRC_S:     imm_full = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            SRC_B:     imm_full = {{51{instr[31]}}, instr[31], instr[7],
                                   instr[30:25], instr[11:8], 1'b0};
            SRC_U:     imm_full = {{32{instr[31]}}, instr[31:12], 12'd0};
            SRC_J:     imm_full = {{43{instr[31]}}, instr[31], instr[19:12],
                                   instr[20], instr[30:21], 1'b0};
            SRC_SHAMT: imm_full = {58'd0, (SHAMT_WIDE ? instr[25] : 1'b0),
                                   instr[24:20]};
            SRC_CSR:   imm_full = {59'd0, instr[19:15]};
            default: begin
                imm_full    = 64'd0;
                imm_illegal = 1'b1;
            end
        endcase
    end

    // Opcode bits and (for XLEN=32) the upper half of imm_full are not needed.
    logic unused_bits;
    assign unused_bits = ^{instr[6:0], imm_full};

    assign new_entry.imm     = imm_full[XLEN-1:0];
    assign new_entry.tag     = bus.in_tag;
    assign new_entry.illegal = imm_illegal;

    // -----------------------------------------------------------------------
    // Handshakes. in_ready never looks at out_ready, which breaks the
    // combinational ready chain through this stage.
    // -----------------------------------------------------------------------
    assign bus.in_ready = rst_n & ~skid_valid_reg;
    assign accept       = bus.in_valid & bus.in_ready;
    assign transfer     = main_valid_reg & bus.out_ready;

    // -----------------------------------------------------------------------
    // Buffer next-state. Flush wins over every handshake; an entry accepted
    // in the flush cycle is simply not stored.
    // -----------------------------------------------------------------------
    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;

        if (bus.flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!main_valid_reg || transfer) begin
            // Main slot is free for this edge.
            if (skid_valid_reg) begin
                // Oldest entry lives in the skid; it moves up first.
                main_next       = skid_reg;
                main_valid_next = 1'b1;
                if (accept) begin
                    skid_next = new_entry;
                end else begin
                    skid_valid_next = 1'b0;
                end
            end else if (accept) begin
                main_next       = new_entry;
                main_valid_next = 1'b1;
            end else begin
                main_valid_next = 1'b0;
            end
        end else if (accept) begin
            // Main is stalled: park the new entry in the skid.
            skid_next       = new_entry;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    assign bus.out_valid   = main_valid_reg;
    assign bus.out_imm     = main_reg.imm;
    assign bus.out_tag     = main_reg.tag;
    assign bus.out_illegal = main_reg.illegal;

endmodule

// File: doc/imm_extend_stage.md
# imm_extend_stage

Pipelined, parametrised immediate generator for the pipelined core's decode stage. Extracts and sign- or zero-extends every RV32I/RV64I immediate format to XLEN bits. Covers I, S, B, U and J formats, shift amounts and CSR uimm, and flags illegal format selects. Sits between instruction fetch/decode and the execute-stage register. A 2-entry valid/ready skid buffer gives full throughput under backpressure.

## Interface

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_WIDTH, 5, width of a sideband tag carried alongside each immediate, unmodified.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous pipeline flush; drops all held entries.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  block can accept this cycle.
- in_instr  input  32  raw instruction word.
- in_imm_src  input  3  format select (encoding below).
- in_tag  input  TAG_WIDTH  sideband tag.
- out_valid  output  1  out_* fields hold a result.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  extended immediate.
- out_tag  output  TAG_WIDTH  tag of that result.
- out_illegal  output  1  result came from illegal in_imm_src.

## Operation

- Encoding of in_imm_src. All sign extension is from instr[31] to XLEN.
  - 000 I: instr[31:20].
  - 001 S: {instr[31:25], instr[11:7]}.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 U: {instr[31:12], 12'b0}.
  - 100 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 101 SHAMT: zero-extended. instr[24:20] when XLEN=32; instr[25:20] when XLEN=64.
  - 110 CSR uimm: zero-extended instr[19:15].
  - 111 illegal: imm = 0, illegal = 1.
- Extraction is combinational on the input side. The result, tag and illegal bit are registered together as one entry.
- Storage is two entries: main (drives out_*) and skid.
- Accept condition: in_valid & in_ready. Output transfer condition: out_valid & out_ready.
- in_ready = rst_n & !skid_valid.
- On accept:
  - If main is empty or transferring this cycle, the entry loads main. If the skid is full, main loads from the skid and the new entry loads the skid.
  - Otherwise the entry loads the skid.
- When main transfers and the skid is full, the skid moves to main.
- Order is strictly preserved. There is no loss or duplication.
- flush has priority over all handshakes:
  - Next cycle, main and skid are both invalid.
  - An input accepted in the flush cycle is dropped.
  - in_ready stays 1 during flush unless the skid is full.
- Reset values: out_valid=0, out_imm=0, out_tag=0, out_illegal=0, skid empty. in_ready=0 while rst_n=0 and 1 in the first cycle after release.
- Reset mid-operation discards all entries exactly as flush does.
- out_* are held stable while out_valid=1 and out_ready=0.

## Timing

- Latency is 1 cycle: an input accepted at edge N appears on out_* after edge N (cycle N+1).
- Throughput is 1 per cycle while out_ready=1.
- With out_ready held 0: main fills, then the skid fills, and in_ready falls in the cycle after the second accept. At most 2 entries are held.
- When out_ready rises with both entries full:
  - The skid entry appears at out_* the next cycle.
  - in_ready returns to 1 in that same next cycle.
- Simultaneous accept and transfer with the skid empty means pass-through: main is replaced and the skid stays empty.
- in_ready is a function of registered state and rst_n only. There is no combinational path from out_ready to in_ready.

## Test plan

- Format sweep, XLEN=32, out_ready=1. Each result must appear one cycle after accept:
  - instr 0xFFF00093 src I → 0xFFFFFFFF.
  - 0xFE512E23 src S → 0xFFFFFFFC.
  - 0xFE000CE3 src B → 0xFFFFFFF8.
  - 0x123450B7 src U → 0x12345000.
  - 0x001000EF src J → 0x00000800.
  - src 111 → imm 0x0, out_illegal=1.
- XLEN=64:
  - 0x800000B7 src U → 0xFFFFFFFF80000000.
  - 0x03F09093 src SHAMT → 0x3F.
  - 0x000F5073 src CSR → 0x1E.
- Backpressure: hold out_ready=0 and stream tags 1,2,3 with in_valid=1.
  - Tags 1 and 2 are accepted; in_ready=0 while tag 3 is held.
  - Release out_ready: out_tag must sequence 1,2,3 with no gaps or duplicates.
  - in_ready must return to 1 one cycle after release.
- Flush with both entries full and a simultaneous in_valid:
  - Next cycle, out_valid=0 and in_ready=1.
  - The flushed-cycle input never appears at the output.
- Reset mid-stream: assert rst_n=0 for one cycle with both entries full.
  - While asserted, in_ready=0.
  - Next cycle, out_valid=0 and out_imm=0.
  - Streaming restarts cleanly.
- Random valid/ready stress, 10k cycles, against a scoreboard model: output sequence equals input sequence, and no out_* changes while stalled.
